mult_result_buffer: RTL and testbench

- AXI4-Stream elastic buffer directly downstream of the floating-point multiplier in the FFT datapath.
- Absorbs single-precision products (via the multiplier's result tvalid/tready/tdata) while the next FFT stage stalls, so the multiplier pipeline keeps draining.
- Re-emits products in order and marks FFT frame boundaries with tlast every FRAME_LEN beats.
- Reports fill level and a completed-frame count.

---
 rtl/fft_axis_pkg.sv | 24 ++
 rtl/axis_frame_tagger.sv | 47 ++++
 rtl/mult_result_buffer.sv | 82 ++++++++
 tb/tb_mult_result_buffer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_axis_pkg.sv
// Shared types, constants and width helper for the FFT AXI4-Stream datapath blocks.
package fft_axis_pkg;

  localparam int FLOAT_W       = 32;
  localparam int DEF_FRAME_LEN = 10;

  localparam logic [FLOAT_W-1:0] F_4    = 32'h4080_0000;
  localparam logic [FLOAT_W-1:0] F_16   = 32'h4180_0000;
  localparam logic [FLOAT_W-1:0] F_64   = 32'h4280_0000;
  localparam logic [FLOAT_W-1:0] F_256  = 32'h4380_0000;
  localparam logic [FLOAT_W-1:0] F_1024 = 32'h4480_0000;
  localparam logic [FLOAT_W-1:0] F_4096 = 32'h4580_0000;

  // Bits needed to index n items; never less than 1.
  function automatic int width_of(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/axis_frame_tagger.sv
// Counts output beats into frames: drives tlast, a frame_done pulse and the frame counter.
module axis_frame_tagger
  import fft_axis_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int FCNT_W    = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              clr,
  input  logic              pop,
  input  logic              valid,
  output logic              tlast,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int BEAT_W = width_of(FRAME_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  logic [BEAT_W-1:0] beat;
  logic              end_beat;

  assign end_beat = (beat == LAST_BEAT);
  assign tlast    = valid && end_beat;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else if (clr) begin
      // Flush restarts the frame but keeps the history of completed frames.
      beat       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && end_beat;
      if (pop) begin
        beat <= end_beat ? '0 : beat + BEAT_ONE;
        if (end_beat) frame_cnt <= frame_cnt + FCNT_ONE;
      end
    end
  end

endmodule

// File: rtl/mult_result_buffer.sv
// First-word fall-through elastic buffer behind the FP multiplier, with frame tagging on output.
module mult_result_buffer
  import fft_axis_pkg::*;
#(
  parameter int DATA_W    = FLOAT_W,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int FCNT_W    = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     clr,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [width_of(DEPTH):0] level,
  output logic                     frame_done,
  output logic [FCNT_W-1:0]        frame_cnt
);

  localparam int ADDR_W = width_of(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic              full, empty, push, pop;

  // Wrap bit distinguishes full from empty when the index bits coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  assign s_axis_tready = !full;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = mem[rd_ptr[ADDR_W-1:0]];

  assign push = s_axis_tvalid && !full;
  assign pop  = !empty && m_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge aclk) begin
    if (push && !clr) mem[wr_ptr[ADDR_W-1:0]] <= s_axis_tdata;
  end

  axis_frame_tagger #(
    .FRAME_LEN(FRAME_LEN),
    .FCNT_W   (FCNT_W)
  ) u_tagger (
    .aclk      (aclk),
    .areset    (areset),
    .clr       (clr),
    .pop       (pop),
    .valid     (m_axis_tvalid),
    .tlast     (m_axis_tlast),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

endmodule

// File: tb/tb_mult_result_buffer.sv
// Randomized scenario bench for mult_result_buffer against a queue-based reference model.
module tb_mult_result_buffer;
  import fft_axis_pkg::*;

  localparam int DEPTH = 16;
  localparam int FL    = 10;

  logic        aclk = 1'b0, areset = 1'b1, clr = 1'b0;
  logic        s_tvalid = 1'b0, m_tready = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tready, m_tvalid, m_tlast, frame_done;
  logic [31:0] m_tdata;
  logic [4:0]  level;
  logic [15:0] frame_cnt;

  int          checks = 0, failures = 0;
  logic [31:0] mq[$];
  int          mbeat = 0, mfcnt = 0, npushed = 0;
  bit          mdone = 1'b0;
  logic [31:0] burst_w [10];

  mult_result_buffer #(.DATA_W(32), .DEPTH(DEPTH), .FRAME_LEN(FL), .FCNT_W(16)) dut (
    .aclk(aclk), .areset(areset), .clr(clr),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast), .level(level), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  // Clock edge plus reference-model update from the inputs currently applied.
  task automatic advance();
    bit pu, po;
    pu = s_tvalid && (mq.size() < DEPTH);
    po = m_tready && (mq.size() != 0);
    @(posedge aclk);
    if (clr) begin
      mq.delete(); mbeat = 0; mdone = 1'b0;
    end else begin
      mdone = po && (mbeat == FL - 1);
      if (po) begin
        void'(mq.pop_front());
        if (mbeat == FL - 1) begin mbeat = 0; mfcnt = (mfcnt + 1) % 65536; end
        else mbeat++;
      end
      if (pu) begin mq.push_back(s_tdata); npushed++; end
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks += 6;
    if (m_tvalid !== 1'b0)   begin failures++; $display("FAIL reset tvalid got=%b exp=0", m_tvalid); end
    if (m_tlast !== 1'b0)    begin failures++; $display("FAIL reset tlast got=%b exp=0", m_tlast); end
    if (s_tready !== 1'b1)   begin failures++; $display("FAIL reset tready got=%b exp=1", s_tready); end
    if (level !== 5'd0)      begin failures++; $display("FAIL reset level got=%0d exp=0", level); end
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset frame_cnt got=%0d exp=0", frame_cnt); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset frame_done got=%b exp=0", frame_done); end
    @(negedge aclk); areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_burst();
    int ndone = 0;
    m_tready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      s_tvalid = (c < 10);
      s_tdata  = (c < 10) ? burst_w[c] : 32'h0;
      @(negedge aclk);
      checks += 5; ndone += int'(frame_done);
      if (m_tvalid !== (mq.size() != 0)) begin failures++; $display("FAIL burst tvalid got=%b exp=%b", m_tvalid, mq.size() != 0); end
      if (mq.size() != 0) begin checks++; if (m_tdata !== mq[0]) begin failures++; $display("FAIL burst tdata got=%h exp=%h", m_tdata, mq[0]); end end
      if (m_tlast !== (mq.size() != 0 && mbeat == FL - 1)) begin failures++; $display("FAIL burst tlast got=%b beat=%0d", m_tlast, mbeat); end
      if (level !== 5'(mq.size())) begin failures++; $display("FAIL burst level got=%0d exp=%0d", level, mq.size()); end
      if (s_tready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL burst tready got=%b exp=%b", s_tready, mq.size() < DEPTH); end
      if (frame_done !== mdone || frame_cnt !== 16'(mfcnt)) begin failures++; $display("FAIL burst frame got=%b/%0d exp=%b/%0d", frame_done, frame_cnt, mdone, mfcnt); end
      advance();
    end
    checks += 2;
    if (ndone != 1) begin failures++; $display("FAIL burst done_pulses got=%0d exp=1", ndone); end
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL burst frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_fill_stall();
    int base = npushed;
    logic [15:0] fc0 = frame_cnt;
    m_tready = 1'b0; s_tdata = F_16;
    for (int c = 0; c < 200; c++) begin
      if (c == 20) begin
        checks += 2;
        if (level !== 5'd16) begin failures++; $display("FAIL stall level got=%0d exp=16", level); end
        if (s_tready !== 1'b0) begin failures++; $display("FAIL stall tready got=%b exp=0", s_tready); end
        m_tready = 1'b1;
      end
      s_tvalid = (npushed - base < 20);
      if (npushed - base >= 20 && mq.size() == 0) break;
      @(negedge aclk);
      checks += 5;
      if (m_tvalid !== (mq.size() != 0)) begin failures++; $display("FAIL stall tvalid got=%b exp=%b", m_tvalid, mq.size() != 0); end
      if (mq.size() != 0) begin checks++; if (m_tdata !== mq[0]) begin failures++; $display("FAIL stall tdata got=%h exp=%h", m_tdata, mq[0]); end end
      if (m_tlast !== (mq.size() != 0 && mbeat == FL - 1)) begin failures++; $display("FAIL stall tlast got=%b beat=%0d", m_tlast, mbeat); end
      if (level !== 5'(mq.size())) begin failures++; $display("FAIL stall level got=%0d exp=%0d", level, mq.size()); end
      if (s_tready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL stall tready got=%b exp=%b", s_tready, mq.size() < DEPTH); end
      if (frame_done !== mdone || frame_cnt !== 16'(mfcnt)) begin failures++; $display("FAIL stall frame got=%b/%0d exp=%b/%0d", frame_done, frame_cnt, mdone, mfcnt); end
      advance();
    end
    checks += 2;
    if (mq.size() != 0 || npushed - base != 20) begin failures++; $display("FAIL stall drain_timeout left=%0d pushed=%0d", mq.size(), npushed - base); end
    if (frame_cnt - fc0 !== 16'd2) begin failures++; $display("FAIL stall frames got=%0d exp=2", frame_cnt - fc0); end
  endtask

  task automatic test_full_toggle();
    int t = 0;
    for (int c = 0; c < 300; c++) begin
      if (t == 0 && mq.size() == DEPTH) t = 1;
      if (t >= 1) t++;
      m_tready = (t >= 1 && t <= 32) ? (t % 2 == 0) : (t > 32);
      s_tvalid = (t <= 32);
      s_tdata  = $urandom;
      if (t > 32 && mq.size() == 0) break;
      @(negedge aclk);
      checks += 5;
      if (t >= 4 && t <= 32) begin checks++; if (level < 5'd15) begin failures++; $display("FAIL toggle level_band got=%0d exp=15..16", level); end end
      if (m_tvalid !== (mq.size() != 0)) begin failures++; $display("FAIL toggle tvalid got=%b exp=%b", m_tvalid, mq.size() != 0); end
      if (mq.size() != 0) begin checks++; if (m_tdata !== mq[0]) begin failures++; $display("FAIL toggle tdata got=%h exp=%h", m_tdata, mq[0]); end end
      if (m_tlast !== (mq.size() != 0 && mbeat == FL - 1)) begin failures++; $display("FAIL toggle tlast got=%b beat=%0d", m_tlast, mbeat); end
      if (level !== 5'(mq.size())) begin failures++; $display("FAIL toggle level got=%0d exp=%0d", level, mq.size()); end
      if (s_tready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL toggle tready got=%b exp=%b", s_tready, mq.size() < DEPTH); end
      if (frame_done !== mdone || frame_cnt !== 16'(mfcnt)) begin failures++; $display("FAIL toggle frame got=%b/%0d exp=%b/%0d", frame_done, frame_cnt, mdone, mfcnt); end
      advance();
    end
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL toggle drain_timeout left=%0d exp=0", mq.size()); end
  endtask

  task automatic test_backpressure();
    logic held_last = 1'b0;
    for (int c = 0; c < 100; c++) begin
      s_tvalid = (c <= 5);
      s_tdata  = (c == 0) ? F_256 : $urandom;
      m_tready = (c > 5);
      if (c > 5 && mq.size() == 0) break;
      @(negedge aclk);
      if (c == 1) held_last = m_tlast;
      if (c >= 1 && c <= 5) begin
        checks += 2;
        if (m_tdata !== F_256) begin failures++; $display("FAIL hold tdata got=%h exp=%h", m_tdata, F_256); end
        if (m_tlast !== held_last) begin failures++; $display("FAIL hold tlast got=%b exp=%b", m_tlast, held_last); end
      end
      checks += 3;
      if (m_tvalid !== (mq.size() != 0)) begin failures++; $display("FAIL hold tvalid got=%b exp=%b", m_tvalid, mq.size() != 0); end
      if (mq.size() != 0) begin checks++; if (m_tdata !== mq[0]) begin failures++; $display("FAIL hold qdata got=%h exp=%h", m_tdata, mq[0]); end end
      if (m_tlast !== (mq.size() != 0 && mbeat == FL - 1)) begin failures++; $display("FAIL hold qlast got=%b beat=%0d", m_tlast, mbeat); end
      if (level !== 5'(mq.size())) begin failures++; $display("FAIL hold level got=%0d exp=%0d", level, mq.size()); end
      advance();
    end
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL hold drain_timeout left=%0d exp=0", mq.size()); end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0; s_tvalid = 1'b1;
    for (int c = 0; c < 20 && mq.size() < 7; c++) begin
      s_tdata = $urandom;
      advance();
    end
    s_tvalid = 1'b0;
    checks++;
    if (level !== 5'd7) begin failures++; $display("FAIL rstmid pre_level got=%0d exp=7", level); end
    #2 areset = 1'b1;
    #1;
    mq.delete(); mbeat = 0; mfcnt = 0; mdone = 1'b0;
    checks += 6;
    if (m_tvalid !== 1'b0)   begin failures++; $display("FAIL rstmid tvalid got=%b exp=0", m_tvalid); end
    if (m_tlast !== 1'b0)    begin failures++; $display("FAIL rstmid tlast got=%b exp=0", m_tlast); end
    if (s_tready !== 1'b1)   begin failures++; $display("FAIL rstmid tready got=%b exp=1", s_tready); end
    if (level !== 5'd0)      begin failures++; $display("FAIL rstmid level got=%0d exp=0", level); end
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL rstmid frame_cnt got=%0d exp=0", frame_cnt); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL rstmid frame_done got=%b exp=0", frame_done); end
    @(negedge aclk); areset = 1'b0;
    @(posedge aclk); #1;
  endtask

  task automatic test_clr();
    logic [15:0] fc0;
    int nout = 0, lastpos = -1, ndone = 0, base;
    m_tready = 1'b0; s_tvalid = 1'b1;
    for (int c = 0; c < 20 && mq.size() < 7; c++) begin s_tdata = $urandom; advance(); end
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (4) advance();
    checks++;
    if (level !== 5'd3 || mbeat != 4) begin failures++; $display("FAIL clr pre_level got=%0d exp=3", level); end
    fc0 = frame_cnt;
    clr = 1'b1; s_tvalid = 1'b1; s_tdata = $urandom;
    advance();
    clr = 1'b0; s_tvalid = 1'b0;
    checks += 4;
    if (level !== 5'd0)     begin failures++; $display("FAIL clr level got=%0d exp=0", level); end
    if (m_tvalid !== 1'b0)  begin failures++; $display("FAIL clr tvalid got=%b exp=0", m_tvalid); end
    if (frame_cnt !== fc0)  begin failures++; $display("FAIL clr frame_cnt got=%0d exp=%0d", frame_cnt, fc0); end
    if (frame_done !== 1'b0) begin failures++; $display("FAIL clr frame_done got=%b exp=0", frame_done); end
    base = npushed;
    for (int c = 0; c < 100; c++) begin
      s_tvalid = (npushed - base < 10);
      s_tdata  = $urandom;
      if (npushed - base >= 10 && mq.size() == 0) break;
      @(negedge aclk);
      ndone += int'(frame_done);
      if (m_tvalid && m_tready) begin nout++; if (m_tlast && lastpos < 0) lastpos = nout; end
      checks += 3;
      if (mq.size() != 0) begin checks++; if (m_tdata !== mq[0]) begin failures++; $display("FAIL clr tdata got=%h exp=%h", m_tdata, mq[0]); end end
      if (m_tlast !== (mq.size() != 0 && mbeat == FL - 1)) begin failures++; $display("FAIL clr tlast got=%b beat=%0d", m_tlast, mbeat); end
      if (level !== 5'(mq.size())) begin failures++; $display("FAIL clr qlevel got=%0d exp=%0d", level, mq.size()); end
      if (frame_done !== mdone || frame_cnt !== 16'(mfcnt)) begin failures++; $display("FAIL clr frame got=%b/%0d exp=%b/%0d", frame_done, frame_cnt, mdone, mfcnt); end
      advance();
    end
    @(negedge aclk); ndone += int'(frame_done);
    checks += 3;
    if (lastpos != 10) begin failures++; $display("FAIL clr tlast_pos got=%0d exp=10", lastpos); end
    if (ndone != 1) begin failures++; $display("FAIL clr done_pulses got=%0d exp=1", ndone); end
    if (frame_cnt !== fc0 + 16'd1) begin failures++; $display("FAIL clr frames got=%0d exp=%0d", frame_cnt, fc0 + 16'd1); end
    @(posedge aclk); #1;
  endtask

  task automatic test_wrap();
    int base = npushed, ndone = 0;
    logic [15:0] fc0 = frame_cnt;
    for (int c = 0; c < 2000; c++) begin
      s_tvalid = (npushed - base < 100) && ($urandom_range(3) != 0);
      s_tdata  = $urandom;
      m_tready = ($urandom_range(2) != 0);
      if (npushed - base >= 100 && mq.size() == 0) break;
      @(negedge aclk);
      ndone += int'(frame_done);
      checks += 4;
      if (m_tvalid !== (mq.size() != 0)) begin failures++; $display("FAIL wrap tvalid got=%b exp=%b", m_tvalid, mq.size() != 0); end
      if (mq.size() != 0) begin checks++; if (m_tdata !== mq[0]) begin failures++; $display("FAIL wrap tdata got=%h exp=%h", m_tdata, mq[0]); end end
      if (m_tlast !== (mq.size() != 0 && mbeat == FL - 1)) begin failures++; $display("FAIL wrap tlast got=%b beat=%0d", m_tlast, mbeat); end
      if (level !== 5'(mq.size())) begin failures++; $display("FAIL wrap level got=%0d exp=%0d", level, mq.size()); end
      if (s_tready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL wrap tready got=%b exp=%b", s_tready, mq.size() < DEPTH); end
      advance();
    end
    @(negedge aclk); ndone += int'(frame_done);
    checks += 3;
    if (mq.size() != 0 || npushed - base != 100) begin failures++; $display("FAIL wrap drain_timeout left=%0d pushed=%0d", mq.size(), npushed - base); end
    if (ndone != 10) begin failures++; $display("FAIL wrap done_pulses got=%0d exp=10", ndone); end
    if (frame_cnt - fc0 !== 16'd10) begin failures++; $display("FAIL wrap frames got=%0d exp=10", frame_cnt - fc0); end
  endtask

  initial begin
    burst_w = '{F_4096, F_1024, F_256, F_64, F_16, F_4, F_4, F_4, F_4, F_4};
    test_reset();
    test_burst();
    test_fill_stall();
    test_full_toggle();
    test_backpressure();
    test_reset_mid();
    test_clr();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
